// File: rtl/sampleq_bus_arbiter_pkg.sv
// Shared constants for the sampleq bus arbiter: FSM encoding, burst counter
// width and the grant-index width helper.
package sampleq_arb_pkg;

    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_GRANT = 1'b1;

    localparam int BCW = 4;

    // Index width for n requesters; never below 1 so a 1-bit id always exists.
    function automatic int calc_idw(input int n);
        for (int w = 1; w < 31; w++) begin
            if ((1 << w) >= n) return w;
        end
        return 31;
    endfunction

endpackage

// File: rtl/sampleq_bus_arbiter_rr_pick.sv
// Combinational round-robin search: scans from last+1, wraps modulo NREQ and
// reaches the previous winner last. The first set request bit wins.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic            found_o,
    output logic [IDW-1:0]  win_o
);

    int             pos;
    logic [IDW-1:0] idx;

    always_comb begin
        found_o = 1'b0;
        win_o   = '0;
        pos     = 0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            // Explicit wrap so non-power-of-two NREQ stays in range.
            pos = int'(last_i) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            idx = IDW'(pos);
            if (!found_o && req_i[idx]) begin
                found_o = 1'b1;
                win_o   = idx;
            end
        end
    end

endmodule

// File: rtl/sampleq_bus_arbiter.sv
// Round-robin bus arbiter for NREQ sampleq queues with a per-owner burst
// limit and a hold input that freezes the current grant.
module sampleq_bus_arbiter
    import sampleq_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int BURST = 2,
    parameter int IDW   = calc_idw(NREQ)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [NREQ-1:0] bus_req,
    input  logic            hold,
    output logic [NREQ-1:0] bus_gnt,
    output logic            gnt_valid,
    output logic [IDW-1:0]  gnt_id,
    output logic [BCW-1:0]  burst_cnt
);

    localparam logic [BCW-1:0] BLIM    = BCW'(BURST - 1);
    localparam logic [BCW-1:0] CNT_MAX = {BCW{1'b1}};
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    logic [0:0]      state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            vld_q, vld_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [BCW-1:0]  cnt_q, cnt_d;

    logic            pick_found;
    logic [IDW-1:0]  pick_id;
    logic            owner_req;
    logic            others_req;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i   (bus_req),
        .last_i  (last_q),
        .found_o (pick_found),
        .win_o   (pick_id)
    );

    assign owner_req  = bus_req[id_q];
    assign others_req = |(bus_req & ~gnt_q);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        if (state_q == ARB_IDLE || !hold) begin
            if (state_q == ARB_GRANT && owner_req && (cnt_q < BLIM || !others_req)) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + BCW'(1);
            end else if (pick_found) begin
                // New grant (or re-grant to a sole requester) restarts the burst.
                state_d        = ARB_GRANT;
                last_d         = pick_id;
                gnt_d          = '0;
                gnt_d[pick_id] = 1'b1;
                vld_d          = 1'b1;
                id_d           = pick_id;
                cnt_d          = '0;
            end else begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                vld_d   = 1'b0;
                id_d    = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            last_q  <= LAST_RST;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_gnt   = gnt_q;
    assign gnt_valid = vld_q;
    assign gnt_id    = id_q;
    assign burst_cnt = cnt_q;

endmodule

// File: tb/tb_sampleq_bus_arbiter.sv
// Directed bench for sampleq_bus_arbiter: a 2-requester/BURST=2 instance and
// a 4-requester/BURST=1 instance, driven with hand-computed grant sequences.
module tb_sampleq_bus_arbiter;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] req2 = '0;
    logic       hold2 = 1'b0;
    logic [1:0] gnt2;
    logic       vld2;
    logic [0:0] id2;
    logic [3:0] cnt2;
    logic [3:0] req4 = '0;
    logic       hold4 = 1'b0;
    logic [3:0] gnt4;
    logic       vld4;
    logic [1:0] id4;
    logic [3:0] cnt4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    sampleq_bus_arbiter #(.NREQ(2), .BURST(2)) u2 (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus_req   (req2),
        .hold      (hold2),
        .bus_gnt   (gnt2),
        .gnt_valid (vld2),
        .gnt_id    (id2),
        .burst_cnt (cnt2)
    );

    sampleq_bus_arbiter #(.NREQ(4), .BURST(1)) u4 (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus_req   (req4),
        .hold      (hold4),
        .bus_gnt   (gnt4),
        .gnt_valid (vld4),
        .gnt_id    (id4),
        .burst_cnt (cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    logic [1:0] rr_gnt [8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
    logic [3:0] rr_cnt [8] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1};
    logic [3:0] w4_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        int pend0, pend1, done, run, last_own, max_run;

        // Reset state
        do_reset();
        chk("rst_gnt", 32'(gnt2), 32'h0);
        chk("rst_vld", 32'(vld2), 32'h0);
        chk("rst_id", 32'(id2), 32'h0);
        chk("rst_cnt", 32'(cnt2), 32'h0);

        // Reset mid-burst drops grant at that edge, pointer restarts
        req2 = 2'b01;
        step();
        chk("mb_gnt", 32'(gnt2), 32'h1);
        reset_n = 1'b0;
        step();
        chk("mb_rst_gnt", 32'(gnt2), 32'h0);
        chk("mb_rst_vld", 32'(vld2), 32'h0);
        chk("mb_rst_cnt", 32'(cnt2), 32'h0);
        reset_n = 1'b1;
        req2 = 2'b11;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("rr_gnt%0d", i), 32'(gnt2), 32'(rr_gnt[i]));
            chk($sformatf("rr_cnt%0d", i), 32'(cnt2), 32'(rr_cnt[i]));
            chk($sformatf("rr_id%0d", i), 32'(id2), (rr_gnt[i] == 2'b10) ? 32'd1 : 32'd0);
        end

        // Sole requester keeps the bus, counter runs past the burst limit
        req2 = 2'b00;
        do_reset();
        req2 = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("sole_gnt%0d", i), 32'(gnt2), 32'h2);
            chk($sformatf("sole_cnt%0d", i), 32'(cnt2), 32'(i));
        end
        req2 = 2'b00;
        step();
        chk("sole_drop_gnt", 32'(gnt2), 32'h0);
        chk("sole_drop_vld", 32'(vld2), 32'h0);
        chk("sole_drop_id", 32'(id2), 32'h0);

        // Hold freezes owner and counter at the burst limit
        do_reset();
        req2 = 2'b11;
        step();
        step();
        chk("hold_pre_cnt", 32'(cnt2), 32'h1);
        hold2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hold_gnt%0d", i), 32'(gnt2), 32'h1);
            chk($sformatf("hold_cnt%0d", i), 32'(cnt2), 32'h1);
        end
        hold2 = 1'b0;
        step();
        chk("hold_rel_gnt", 32'(gnt2), 32'h2);
        chk("hold_rel_cnt", 32'(cnt2), 32'h0);

        // Wrap and fairness with four requesters, BURST=1
        req2 = 2'b00;
        do_reset();
        req4 = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("wrap_gnt%0d", i), 32'(gnt4), 32'(w4_gnt[i]));
        end
        req4 = 4'b1001;
        step();
        chk("fair_gnt0", 32'(gnt4), 32'h8);
        chk("fair_id0", 32'(id4), 32'h3);
        step();
        chk("fair_gnt1", 32'(gnt4), 32'h1);
        chk("fair_id1", 32'(id4), 32'h0);
        req4 = 4'b0000;

        // Two-queue traffic: queue0 has 3 writes, queue1 has 2 reads
        do_reset();
        pend0 = 3; pend1 = 2; done = 0; run = 0; last_own = -1; max_run = 0;
        req2 = 2'b11;
        for (int c = 0; c < 20 && done < 5; c++) begin
            step();
            chk($sformatf("int_not11_%0d", c), 32'(gnt2 == 2'b11), 32'h0);
            if (gnt2 != 2'b00) begin
                if (int'(id2) == last_own) run++;
                else run = 1;
                last_own = int'(id2);
                if (run > max_run) max_run = run;
            end else begin
                last_own = -1;
                run = 0;
            end
            if (gnt2[0] && pend0 > 0) begin pend0--; done++; end
            if (gnt2[1] && pend1 > 0) begin pend1--; done++; end
            req2 = {pend1 > 0, pend0 > 0};
        end
        chk("int_done", 32'(done), 32'd5);
        chk("int_max_run", 32'(max_run <= 2), 32'h1);
        req2 = 2'b00;
        step();
        step();
        chk("int_idle_vld", 32'(vld2), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
